// File: rtl/switch_pkg.sv
// Shared types and constants for the switch debounce/capture slice.
package switch_pkg;

    localparam int unsigned SW_WIDTH                = 16;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } sw_state_t;

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser for asynchronous board inputs.
// Asynchronous active-high reset clears every stage.
module sync_chain #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce_capture.sv
// Synchronises and debounces the switch word, presenting each new stable value once
// over valid/ready. Define SWITCH_CHANGE_COUNT_EN to add the CHANGE_COUNT output.
module switch_debounce_capture
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SWITCHES_RAW,
    output logic [WIDTH-1:0] SWITCHES_STABLE,
    output logic             DATA_VALID,
    input  logic             DATA_READY,
`ifdef SWITCH_CHANGE_COUNT_EN
    output logic [15:0]      CHANGE_COUNT,
`endif
    output logic             BUSY
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    sw_state_t        state_q, state_d;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             valid_q, valid_d;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (SWITCHES_RAW),
        .dout (sync_w)
    );

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (sync_w != stable_q) begin
                    cand_d  = sync_w;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_w != cand_q) begin
                    cand_d = sync_w;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A bounce that settled back on the presented word is dropped silently.
                    if (cand_q != stable_q) begin
                        stable_d = cand_q;
                        valid_d  = 1'b1;
                        state_d  = PRESENT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (valid_q && DATA_READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
        end
    end

    assign SWITCHES_STABLE = stable_q;
    assign DATA_VALID      = valid_q;
    assign BUSY            = (state_q != IDLE);

`ifdef SWITCH_CHANGE_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (valid_q && DATA_READY && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign CHANGE_COUNT = count_q;
`endif

endmodule

// File: tb/tb_switch_debounce_capture.sv
// Scoreboard bench for switch_debounce_capture (DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
// Expected words are queued when driven and popped on each accepted handshake.
module tb_switch_debounce_capture;

    logic        CLK;
    logic        RESET;
    logic [15:0] SWITCHES_RAW;
    logic [15:0] SWITCHES_STABLE;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        BUSY;
`ifdef SWITCH_CHANGE_COUNT_EN
    logic [15:0] CHANGE_COUNT;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] sb_q[$];

    switch_debounce_capture #(
        .WIDTH           (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SWITCHES_RAW    (SWITCHES_RAW),
        .SWITCHES_STABLE (SWITCHES_STABLE),
        .DATA_VALID      (DATA_VALID),
        .DATA_READY      (DATA_READY),
`ifdef SWITCH_CHANGE_COUNT_EN
        .CHANGE_COUNT    (CHANGE_COUNT),
`endif
        .BUSY            (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so valid && ready here means the next rising edge accepts.
    always @(negedge CLK) begin
        if (!RESET && DATA_VALID && DATA_READY) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 32'(sb_q.size()), 32'd1);
            end else begin
                check("word", 32'(SWITCHES_STABLE), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_empty(input string tag, input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check(tag, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        cycles(2);
    endtask

    task automatic present_word(input logic [15:0] w, input string tag);
        SWITCHES_RAW = w;
        sb_q.push_back(w);
        wait_empty(tag, 60);
    endtask

    initial begin
        int edges;

        // Test 1: reset with a nonzero word on the switches
        RESET        = 1'b1;
        DATA_READY   = 1'b1;
        SWITCHES_RAW = 16'h1234;
        #1;
        check("rst_stable", 32'(SWITCHES_STABLE), 32'h0);
        check("rst_valid", 32'(DATA_VALID), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
`ifdef SWITCH_CHANGE_COUNT_EN
        check("rst_count", 32'(CHANGE_COUNT), 32'h0);
`endif
        sb_q.push_back(16'h1234);
        #19;
        RESET = 1'b0;
        edges = 0;
        while (!DATA_VALID && edges < 50) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check("t1_latency_in_range", 32'(edges >= 10 && edges <= 12), 32'd1);
        wait_empty("t1_timeout", 40);
        check("t1_stable", 32'(SWITCHES_STABLE), 32'h1234);
        check("t1_busy", 32'(BUSY), 32'h0);
        check("t1_valid_low", 32'(DATA_VALID), 32'h0);

        // Test 2: bouncing between two values never reaches the debounce count
        for (int i = 0; i < 40; i++) begin
            SWITCHES_RAW = (((i / 3) % 2) != 0) ? 16'h00FE : 16'h00FF;
            cycles(1);
        end
        present_word(16'h00FF, "t2_timeout");
        check("t2_stable", 32'(SWITCHES_STABLE), 32'h00FF);

        // Test 3: a short glitch returning to the presented word
        present_word(16'h1234, "t3_pre_timeout");
        SWITCHES_RAW = 16'h1235;
        cycles(4);
        SWITCHES_RAW = 16'h1234;
        cycles(30);
        check("t3_stable", 32'(SWITCHES_STABLE), 32'h1234);
        check("t3_busy", 32'(BUSY), 32'h0);

        // Test 4: switch change while a word waits for ready
        DATA_READY   = 1'b0;
        SWITCHES_RAW = 16'hABCD;
        sb_q.push_back(16'hABCD);
        edges = 0;
        while (!DATA_VALID && edges < 50) begin
            cycles(1);
            edges++;
        end
        check("t4_valid_rise", 32'(DATA_VALID), 32'h1);
        SWITCHES_RAW = 16'h5555;
        sb_q.push_back(16'h5555);
        cycles(20);
        check("t4_hold_stable", 32'(SWITCHES_STABLE), 32'hABCD);
        check("t4_hold_valid", 32'(DATA_VALID), 32'h1);
        check("t4_hold_busy", 32'(BUSY), 32'h1);
        DATA_READY = 1'b1;
        wait_empty("t4_timeout", 60);
        check("t4_stable", 32'(SWITCHES_STABLE), 32'h5555);

        // Test 5: asynchronous reset in the middle of a debounce interval
        SWITCHES_RAW = 16'h0F0F;
        cycles(6);
        check("t5_busy_pre", 32'(BUSY), 32'h1);
        @(negedge CLK);
        #2;
        RESET        = 1'b1;
        SWITCHES_RAW = 16'h0000;
        #1;
        check("t5_async_stable", 32'(SWITCHES_STABLE), 32'h0);
        check("t5_async_valid", 32'(DATA_VALID), 32'h0);
        check("t5_async_busy", 32'(BUSY), 32'h0);
`ifdef SWITCH_CHANGE_COUNT_EN
        check("t5_async_count", 32'(CHANGE_COUNT), 32'h0);
`endif
        @(negedge CLK);
        RESET = 1'b0;
        cycles(30);
        check("t5_after_valid", 32'(DATA_VALID), 32'h0);
        check("t5_after_stable", 32'(SWITCHES_STABLE), 32'h0);

`ifdef SWITCH_CHANGE_COUNT_EN
        // Test 6: handshake counter
        for (int w = 1; w <= 5; w++) begin
            present_word(16'(w), "t6_timeout");
        end
        check("t6_count5", 32'(CHANGE_COUNT), 32'd5);
        DATA_READY   = 1'b0;
        SWITCHES_RAW = 16'h0006;
        sb_q.push_back(16'h0006);
        cycles(20);
        check("t6_pending_valid", 32'(DATA_VALID), 32'h1);
        check("t6_pending_count", 32'(CHANGE_COUNT), 32'd5);
        DATA_READY = 1'b1;
        wait_empty("t6_drain_timeout", 40);
        check("t6_count6", 32'(CHANGE_COUNT), 32'd6);
`endif

        cycles(5);
        check("end_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
